// File: rtl/npu_core_top_if.sv
// AXI4-Stream bundle shared by the NPU stream ports.
interface npu_axi_stream_if #(
  parameter int TDATA_WIDTH = 32
) ();
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;

  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/npu_core_top.sv
// Small NPU: loads W then X over an AXI4-Stream slave, computes C = X x W on an
// N x N signed MAC array, and streams C row by row on an AXI4-Stream master.
module npu_core_top #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input logic                clk,
  input logic                rst_n,
  npu_axi_stream_if.slave    s_axis,
  npu_axi_stream_if.master   m_axis
);

  localparam int N  = ARRAY_SIZE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * DATA_WIDTH;

  localparam logic [1:0] LOAD_W  = 2'd0;
  localparam logic [1:0] LOAD_X  = 2'd1;
  localparam logic [1:0] COMPUTE = 2'd2;
  localparam logic [1:0] OUTPUT  = 2'd3;

  logic [1:0]                   state;
  logic [CW-1:0]                cnt;
  logic                         cnt_last;
  logic signed [DATA_WIDTH-1:0] w_reg [N][N];
  logic signed [DATA_WIDTH-1:0] x_reg [N][N];
  logic signed [ACC_WIDTH-1:0]  acc   [N][N];
  logic signed [PW-1:0]         prod  [N][N];
  logic                         s_ready;
  logic                         s_fire;
  logic [CW-1:0]                row_sel;
  logic [N*ACC_WIDTH-1:0]       row_data;
  logic                         out_valid;
  logic                         out_last;
  logic [N*ACC_WIDTH-1:0]       out_data;

  assign cnt_last      = (cnt == CW'(N - 1));
  assign s_ready       = rst_n && ((state == LOAD_W) || (state == LOAD_X));
  assign s_fire        = s_ready && s_axis.tvalid;
  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = out_valid;
  assign m_axis.tlast  = out_last;
  assign m_axis.tdata  = out_data;

  // PE products for the current compute step k = cnt
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        prod[i][j] = x_reg[i][cnt] * w_reg[cnt][j];
      end
    end
  end

  // Row presented next: the pending row before the first beat, the following row once a beat is out
  always_comb begin
    row_sel  = out_valid ? (cnt + CW'(1)) : cnt;
    row_data = '0;
    for (int unsigned j = 0; j < N; j++) begin
      row_data[j*ACC_WIDTH +: ACC_WIDTH] = acc[row_sel][j];
    end
  end

  // Frame sequencing, operand capture, accumulation and registered output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD_W;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned j = 0; j < N; j++) begin
          w_reg[i][j] <= '0;
          x_reg[i][j] <= '0;
          acc[i][j]   <= '0;
        end
      end
    end else begin
      case (state)
        LOAD_W: begin
          if (s_fire) begin
            for (int unsigned j = 0; j < N; j++) begin
              w_reg[cnt][j] <= s_axis.tdata[j*DATA_WIDTH +: DATA_WIDTH];
            end
            if (s_axis.tlast) begin
              cnt <= '0;
            end else if (cnt_last) begin
              state <= LOAD_X;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        LOAD_X: begin
          if (s_fire) begin
            for (int unsigned j = 0; j < N; j++) begin
              x_reg[cnt][j] <= s_axis.tdata[j*DATA_WIDTH +: DATA_WIDTH];
            end
            // Final X beat proceeds whether or not tlast is present; tlast earlier aborts
            if (cnt_last) begin
              state <= COMPUTE;
              cnt   <= '0;
              for (int unsigned i = 0; i < N; i++) begin
                for (int unsigned j = 0; j < N; j++) begin
                  acc[i][j] <= '0;
                end
              end
            end else if (s_axis.tlast) begin
              state <= LOAD_W;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        COMPUTE: begin
          for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
              acc[i][j] <= acc[i][j] + ACC_WIDTH'(prod[i][j]);
            end
          end
          if (cnt_last) begin
            state <= OUTPUT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= row_data;
            out_last  <= cnt_last;
          end else if (m_axis.tready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              state     <= LOAD_W;
              cnt       <= '0;
            end else begin
              cnt      <= cnt + CW'(1);
              out_data <= row_data;
              out_last <= (row_sel == CW'(N - 1));
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_npu_core_top.sv
// Self-checking bench for npu_core_top: table vectors, random frames against a
// matrix-product model, tready stalls, tlast abort and mid-compute reset.
module tb_npu_core_top;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  npu_axi_stream_if #(.TDATA_WIDTH(N*DW)) s_if ();
  npu_axi_stream_if #(.TDATA_WIDTH(N*AW)) m_if ();

  npu_core_top #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_axis (s_if),
    .m_axis (m_if)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_last   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  int cur_w [N][N];
  int cur_x [N][N];
  int exp_c [N][N];

  typedef struct {
    int w [N][N];
    int x [N][N];
    int c [N][N];
    int toggle;
  } vec_t;
  vec_t vecs [3];

  task automatic check(input string name, input logic [N*AW-1:0] act, input logic [N*AW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*DW-1:0] row_w(input int k);
    logic [N*DW-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++) r[j*DW +: DW] = DW'(cur_w[k][j]);
    return r;
  endfunction

  function automatic logic [N*DW-1:0] row_x(input int k);
    logic [N*DW-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++) r[j*DW +: DW] = DW'(cur_x[k][j]);
    return r;
  endfunction

  // Plain matrix product C = X x W
  task automatic model();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        exp_c[i][j] = 0;
        for (int k = 0; k < N; k++) exp_c[i][j] += cur_x[i][k] * cur_w[k][j];
      end
  endtask

  task automatic randomize_mats();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        cur_w[i][j] = int'($urandom_range(255)) - 128;
        cur_x[i][j] = int'($urandom_range(255)) - 128;
      end
  endtask

  task automatic send_beat(input logic [N*DW-1:0] data, input logic last);
    bit got;
    got = 0;
    s_if.tdata  = data;
    s_if.tlast  = last;
    s_if.tvalid = 1'b1;
    for (int b = 0; b < 50 && !got; b++) begin
      @(negedge clk);
      if (s_if.tready) got = 1;
      @(posedge clk);
      #1;
    end
    if (!got) check("s_accept_timeout", 0, 1);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic send_frame();
    for (int k = 0; k < N; k++) send_beat(row_w(k), 1'b0);
    for (int k = 0; k < N; k++) send_beat(row_x(k), k == N-1);
    t_last = cyc;
  endtask

  task automatic collect(input int toggle);
    int row, guard;
    bit stall, ph;
    logic [N*AW-1:0] exp_row, held;
    logic held_last;
    guard = 0;
    while (!m_if.tvalid && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    check("latency", N*AW'(cyc - t_last), N*AW'(N + 1));
    row = 0; guard = 0; stall = 0; ph = 0;
    while (row < N && guard < 100) begin
      m_if.tready = toggle ? ph : 1'b1;
      ph = ~ph;
      if (m_if.tvalid) begin
        if (m_if.tready) begin
          exp_row = '0;
          for (int j = 0; j < N; j++) exp_row[j*AW +: AW] = AW'(exp_c[row][j]);
          check($sformatf("row%0d_data", row), m_if.tdata, exp_row);
          check($sformatf("row%0d_tlast", row), N*AW'(m_if.tlast), N*AW'(row == N-1));
          row++;
        end else begin
          stall = 1; held = m_if.tdata; held_last = m_if.tlast;
        end
      end
      @(posedge clk); #1;
      if (stall) begin
        check("stall_data_hold", m_if.tdata, held);
        check("stall_valid_hold", N*AW'({m_if.tvalid, m_if.tlast}), N*AW'({1'b1, held_last}));
        stall = 0;
      end
      guard++;
    end
    check("beat_count", N*AW'(row), N*AW'(N));
    check("tvalid_drop", N*AW'(m_if.tvalid), '0);
    m_if.tready = 1'b0;
  endtask

  task automatic run_random(input int toggle);
    randomize_mats();
    model();
    send_frame();
    collect(toggle);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stale;
    rst_n = 1'b0;
    s_if.tdata = '0; s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    m_if.tready = 1'b0;

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        vecs[0].w[i][j] = (i == j) ? 1 : 0;
        vecs[1].w[i][j] = -128; vecs[1].x[i][j] = -128; vecs[1].c[i][j] = 65536;
        vecs[2].w[i][j] = 127;  vecs[2].x[i][j] = 127;  vecs[2].c[i][j] = 64516;
      end
    vecs[0].x = '{'{1, 2, 3, 4}, '{5, 6, 7, 8}, '{-1, -2, -3, -4}, '{0, 0, 0, 0}};
    vecs[0].c = '{'{1, 2, 3, 4}, '{5, 6, 7, 8}, '{-1, -2, -3, -4}, '{0, 0, 0, 0}};
    vecs[0].toggle = 0; vecs[1].toggle = 1; vecs[2].toggle = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tready", N*AW'(s_if.tready), '0);
    check("rst_tvalid", N*AW'(m_if.tvalid), '0);
    check("rst_tlast", N*AW'(m_if.tlast), '0);
    check("rst_tdata", m_if.tdata, '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_tready", N*AW'(s_if.tready), N*AW'(1));

    for (int v = 0; v < 3; v++) begin
      cur_w = vecs[v].w; cur_x = vecs[v].x; exp_c = vecs[v].c;
      send_frame();
      collect(vecs[v].toggle);
    end

    for (int r = 0; r < 6; r++) run_random(r % 2);

    // tlast on the third W beat aborts the frame
    randomize_mats();
    send_beat(row_w(0), 1'b0);
    send_beat(row_w(1), 1'b0);
    send_beat(row_w(2), 1'b1);
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      if (m_if.tvalid) stale = 1;
      @(posedge clk); #1;
    end
    check("abort_no_output", N*AW'(stale), '0);
    check("abort_tready", N*AW'(s_if.tready), N*AW'(1));
    run_random(0);

    // Reset during COMPUTE
    randomize_mats();
    send_frame();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check("midrst_tready", N*AW'(s_if.tready), '0);
    check("midrst_tvalid", N*AW'(m_if.tvalid), '0);
    @(posedge clk); #1;
    check("midrst_tdata", m_if.tdata, '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_release_tready", N*AW'(s_if.tready), N*AW'(1));
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      if (m_if.tvalid) stale = 1;
      @(posedge clk); #1;
    end
    check("midrst_no_stale", N*AW'(stale), '0);
    run_random(1);
    run_random(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/npu_core_top.md
Name: npu_core_top

Overview:
- Top level of a small neural processing unit built around an ARRAY_SIZE x ARRAY_SIZE array of signed multiply-accumulate processing elements (PEs).
- Data enters on an AXI4-Stream slave: first a weight matrix W, then an input matrix X.
- The block computes C = X x W and returns C row by row on an AXI4-Stream master.
- Both stream ports are instances of the codebase's npu_axi_stream_if interface bundle.

Parameters:
- ARRAY_SIZE, 4: matrix dimension N; the array holds N*N PEs.
- DATA_WIDTH, 8: width of each signed two's-complement operand element.
- ACC_WIDTH, 32: width of each signed accumulator and each result element.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- s_axis.tdata  in  ARRAY_SIZE*DATA_WIDTH  one matrix row per beat; element j in bits [j*DATA_WIDTH +: DATA_WIDTH].
- s_axis.tvalid  in  1  slave data valid.
- s_axis.tready  out  1  slave ready.
- s_axis.tlast  in  1  marks the final beat of a frame (2N beats).
- m_axis.tdata  out  ARRAY_SIZE*ACC_WIDTH  one result row per beat; element j in bits [j*ACC_WIDTH +: ACC_WIDTH].
- m_axis.tvalid  out  1  master data valid.
- m_axis.tready  in  1  downstream ready.
- m_axis.tlast  out  1  marks the final result row.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - state = LOAD_W, beat counter = 0.
  - All weight, input and accumulator registers = 0.
  - s_axis.tready = 0 while rst_n is low.
  - m_axis.tvalid = 0, m_axis.tdata = 0, m_axis.tlast = 0.
- Handshake: a transfer occurs on any rising edge where tvalid && tready.
  - Master tdata and tlast stay stable while tvalid=1 and tready=0.
  - tvalid never drops before its handshake.
- State machine (registered):
  - LOAD_W: s_axis.tready=1. Beat k (k=0..N-1) writes row k of W. On beat N-1, go to LOAD_X.
  - LOAD_X: s_axis.tready=1. Beat k writes row k of X. On beat N-1, clear all accumulators and go to COMPUTE.
  - COMPUTE: s_axis.tready=0. Runs exactly N cycles, k=0..N-1. In cycle k every PE(i,j) does acc[i][j] += X[i][k]*W[k][j]. After cycle N-1, go to OUTPUT.
  - OUTPUT: s_axis.tready=0, m_axis.tvalid=1. Beat i carries row i of C, i=0..N-1. tlast=1 only on beat N-1. After the beat N-1 handshake, deassert tvalid and go to LOAD_W.
- Latency: if the last X beat is accepted on edge t, m_axis.tvalid rises after edge t+N+1. This is N compute cycles plus one registered-output cycle.
- Arithmetic:
  - Operands are signed.
  - Each product is 2*DATA_WIDTH bits and is sign-extended to ACC_WIDTH.
  - Accumulation wraps modulo 2^ACC_WIDTH with no saturation. With the defaults, overflow cannot occur.
- s_axis.tlast rules:
  - tlast on any beat other than the final X beat aborts the frame. Partial W/X data is discarded and the state returns to LOAD_W with the counter at 0. That beat is still accepted.
  - A missing tlast on the final X beat is ignored; the frame proceeds normally.
- Back-to-back frames: weights are reloaded for every frame. W and X registers keep their values until overwritten.
- Reset mid-operation: rst_n low in any state immediately returns to reset values. No partial result is emitted afterwards.
- s_axis.tvalid low stalls loading indefinitely; no timeout.

Test Plan:
- W = identity, X rows {1,2,3,4},{5,6,7,8},{-1,-2,-3,-4},{0,0,0,0} -> C rows equal X sign-extended to 32 bits; tlast on 4th output beat only; tvalid asserts 5 cycles after last X beat accepted.
- All W and X elements = -128 -> every C element = 65536 (0x00010000). All-127 -> 64516.
- m_axis.tready toggling 1/0 every cycle during OUTPUT -> data held stable on stalled cycles; exactly 4 beats delivered, in order.
- s_axis.tlast asserted on beat 2 of W -> frame aborted, no output; the next clean 8-beat frame produces correct results.
- rst_n pulsed low during COMPUTE -> tvalid=0, tready=0 while low; LOAD_W with tready=1 after release; no stale output.
- Two consecutive frames with different W -> second result uses only the second W; accumulators do not carry over.
